hibrid_mul_sched: RTL and testbench
===================================

# hibrid_mul_sched

Round-robin scheduler that shares one pipelined 34x32 hybrid multiplier among NREQ requesters. It accepts operand pairs over valid/ready, issues at most one product per cycle into the multiplier, and tracks requester tags through the fixed multiplier latency. It returns each 66-bit product with its requester ID. It sits between the NTT/CRT butterfly units and the shared DSP+LUT multiplier instance.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- IDW, 2: requester ID width; must equal clog2(NREQ).
- MUL_LAT, 3: cycles from the edge that registers mul_a/mul_b to the edge where mul_p holds that product.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*34  packed operands; requester i occupies bits [34i+33:34i].
- req_b  in  NREQ*32  packed operands; requester i occupies bits [32i+31:32i].
- req_ready  out  NREQ  one-hot grant, combinational from req_valid, pointer and hold.
- hold  in  1  when 1, no new grants; in-flight products still drain.
- mul_a  out  34  registered operand to the multiplier.
- mul_b  out  32  registered operand to the multiplier.
- mul_p  in  66  multiplier product.
- res_valid  out  1  result strobe. There is no backpressure: the consumer must accept every result.
- res_id  out  IDW  requester that issued this product.
- res_data  out  66  registered product.
- busy  out  1  1 while any accepted request has not yet produced res_valid.

## Operation
- Transfer on requester i: req_valid[i] & req_ready[i] at a rising edge. A requester holds req_valid, req_a and req_b stable until its transfer.
- Arbitration:
  - Search starts at rr_ptr and wraps modulo NREQ. The first requester with req_valid=1 is granted.
  - With hold=1 or rst=1, req_ready = 0.
  - At most one bit of req_ready is set.
- rr_ptr update: after a transfer from g, rr_ptr <= (g+1) mod NREQ. With no transfer, rr_ptr is unchanged.
- Issue stage: on a transfer, mul_a/mul_b <= the granted operands, and tag {v=1, id=g} enters a MUL_LAT-deep shift register. With no transfer, mul_a/mul_b hold their value and v=0 is shifted in.
- Result stage: each cycle, res_valid <= tag_out.v and res_id <= tag_out.id. res_data <= mul_p when tag_out.v=1; otherwise res_data holds.
- busy = OR of all tag v bits plus res_valid-pending; it is combinational from registers.
- Reset values: rr_ptr=0, all tag v=0 and id=0, mul_a=0, mul_b=0, res_valid=0, res_id=0, res_data=0, so busy=0.
- Reset mid-operation: in-flight products are discarded and no res_valid is produced for them. Requesters must reissue.
- hold asserted mid-stream: grants stop on the same cycle. busy deasserts MUL_LAT+1 cycles after the last transfer.
- All requesters valid continuously: grants rotate 0,1,2,3,0,… at one product per cycle.
- Single requester valid continuously: it is granted every cycle, and rr_ptr tracks it.

## Timing
- Latency: a transfer at edge T gives res_valid=1 in the cycle following edge T+MUL_LAT+1 (MUL_LAT+1 cycles after transfer).
- Throughput: one product per cycle, no bubbles. Results are in issue order, and the order is independent of requester.
- The req_ready path is combinational: a request presented in cycle c can be granted in cycle c.
- Every output except req_ready and busy is driven directly from a flop.

## Structure
- Shared package hibrid_mul_pkg:
  - A_W=34, B_W=32, P_W=66;
  - a tag struct {valid, id};
  - default MUL_LAT=3, which must match the multiplier's register count.
- Sub-module rr_arbiter (parameter N): inputs req, ptr and en; outputs a one-hot grant and the encoded index. It is purely combinational.
- The tag pipe and operand/result registers live in the top-level. The multiplier itself is instantiated outside this block.

## Test plan
- Reset, then one request from requester 2 with a=0x3_FFFF_FFFF, b=0xFFFF_FFFF. Expect res_valid exactly MUL_LAT+1 cycles later, res_id=2, res_data=0x3_FFFF_FFFB_0000_0001. Expect busy high for exactly those cycles.
- All 4 requesters valid for 8 cycles with a=i+1, b=0x10. Expect grants 0,1,2,3,0,1,2,3, then results 0x10,0x20,0x30,0x40 repeating with matching res_id on back-to-back cycles.
- Requesters 1 and 3 valid, starting with rr_ptr=0. Expect grant order 1,3,1,3. Drop requester 3 and expect requester 1 granted every cycle.
- hold=1 during streaming. Expect req_ready=0 in the same cycle and in-flight results still delivered. Expect busy=0 MUL_LAT+1 cycles after the last transfer. Release hold and expect rotation to resume from the stored pointer.
- Assert rst with 3 products in flight. Expect no res_valid afterwards, all outputs at reset values, and the next grant going to requester 0.
- Random operands with random valid/hold over 10k cycles. Check each result against a golden a*b product and its issuing id, and check that no result is lost or duplicated.

Source files
------------

// File: rtl/hibrid_mul_pkg.sv
// Shared widths, default multiplier latency and the in-flight tag type for hibrid_mul_sched.
package hibrid_mul_pkg;

  localparam int unsigned A_W             = 34;
  localparam int unsigned B_W             = 32;
  localparam int unsigned P_W             = 66;
  // Must match the register count of the shared multiplier instance.
  localparam int unsigned MUL_LAT_DEFAULT = 3;
  localparam int unsigned MAX_IDW         = 3;

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i (mod N) wins.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum  = {1'b0, ptr_i} + (IW+1)'(k);
      cand = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/hibrid_mul_sched.sv
// Shares one pipelined 34x32 multiplier among NREQ requesters; tags ride alongside the product.
module hibrid_mul_sched
  import hibrid_mul_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  input  logic                hold,
  output logic [A_W-1:0]      mul_a,
  output logic [B_W-1:0]      mul_b,
  input  logic [P_W-1:0]      mul_p,
  output logic                res_valid,
  output logic [IDW-1:0]      res_id,
  output logic [P_W-1:0]      res_data,
  output logic                busy
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_idx;
  logic           xfer;
  logic [A_W-1:0] mul_a_q;
  logic [B_W-1:0] mul_b_q;
  logic           res_valid_q;
  logic [IDW-1:0] res_id_q;
  logic [P_W-1:0] res_data_q;
  logic           unused_id_bits;

  // Entry 0 travels with mul_a/mul_b; entry MUL_LAT lines up with mul_p.
  tag_t tag_q [MUL_LAT+1];
  tag_t tag_d;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .en_i  (~hold & ~rst),
    .gnt_o (req_ready),
    .idx_o (gnt_idx)
  );

  always_comb begin
    xfer        = |req_ready;
    ptr_d       = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
    tag_d.valid = xfer;
    tag_d.id    = MAX_IDW'(gnt_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      for (int unsigned k = 0; k <= MUL_LAT; k++) begin
        tag_q[k] <= '0;
      end
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        mul_a_q <= req_a[32'(gnt_idx)*A_W +: A_W];
        mul_b_q <= req_b[32'(gnt_idx)*B_W +: B_W];
      end
      tag_q[0] <= tag_d;
      for (int unsigned k = 1; k <= MUL_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      res_valid_q <= tag_q[MUL_LAT].valid;
      res_id_q    <= tag_q[MUL_LAT].id[IDW-1:0];
      if (tag_q[MUL_LAT].valid) begin
        res_data_q <= mul_p;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 0; k <= MUL_LAT; k++) begin
      busy = busy | tag_q[k].valid;
    end
  end

  assign unused_id_bits = ^tag_q[MUL_LAT].id;
  assign mul_a          = mul_a_q;
  assign mul_b          = mul_b_q;
  assign res_valid      = res_valid_q;
  assign res_id         = res_id_q;
  assign res_data       = res_data_q;

endmodule

// File: tb/tb_hibrid_mul_sched.sv
// Self-checking bench for hibrid_mul_sched: arbitration model plus product/id scoreboard.
module tb_hibrid_mul_sched;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int MUL_LAT = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*34-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               hold;
  logic [33:0]        mul_a;
  logic [31:0]        mul_b;
  logic [65:0]        mul_p;
  logic               res_valid;
  logic [IDW-1:0]     res_id;
  logic [65:0]        res_data;
  logic               busy;

  hibrid_mul_sched #(
    .NREQ    (NREQ),
    .IDW     (IDW),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .hold      (hold),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // External multiplier: MUL_LAT registers after mul_a/mul_b.
  logic [65:0] p_pipe [MUL_LAT];
  always @(posedge clk) begin
    p_pipe[0] <= 66'(mul_a) * 66'(mul_b);
    for (int k = 1; k < MUL_LAT; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign mul_p = p_pipe[MUL_LAT-1];

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [65:0]    p;
  } exp_t;

  exp_t        sb [$];
  int          passed  = 0;
  int          total   = 0;
  int          res_cnt = 0;
  int          ptr_m   = 0;
  logic [NREQ-1:0] vld;
  logic [33:0] a_arr [NREQ];
  logic [31:0] b_arr [NREQ];

  always @(negedge clk) begin : mon
    exp_t e;
    if (res_valid === 1'b1) begin
      res_cnt++;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL sb_spurious: got id=%0d data=%h expected no result", res_id, res_data);
      end else begin
        e = sb.pop_front();
        if (res_id !== e.id || res_data !== e.p)
          $display("FAIL sb_result: got id=%0d data=%h expected id=%0d data=%h",
                   res_id, res_data, e.id, e.p);
        else passed++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic drive();
    req_valid = vld;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*34 +: 34] = a_arr[i];
      req_b[i*32 +: 32] = b_arr[i];
    end
  endtask

  function automatic int model_grant();
    int idx;
    if (rst || hold) return -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr_m + k) % NREQ;
      if (vld[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [33:0] rand_a();
    return {2'($urandom_range(0, 3)), 32'($urandom)};
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(output int g, output logic [NREQ-1:0] rdy);
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    drive();
    #1;
    g       = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    rdy = req_ready;
    total++;
    if (rdy !== exp_rdy) $display("FAIL req_ready: got %b expected %b", rdy, exp_rdy);
    else passed++;
    if (rst) begin
      sb.delete();
      ptr_m = 0;
    end else if (g >= 0) begin
      e.id = IDW'(g);
      e.p  = 66'(a_arr[g]) * 66'(b_arr[g]);
      sb.push_back(e);
      ptr_m = (g + 1) % NREQ;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    int g;
    logic [NREQ-1:0] rdy;
    rst = 1'b1; hold = 1'b0; vld = '0;
    tick(g, rdy);
    tick(g, rdy);
    rst = 1'b0;
  endtask

  task automatic drain();
    int g;
    int n = 0;
    logic [NREQ-1:0] rdy;
    vld = '0; hold = 1'b0;
    while (sb.size() > 0 && n < 40) begin
      tick(g, rdy);
      n++;
    end
    tick(g, rdy);
    tick(g, rdy);
    total++;
    if (sb.size() != 0) $display("FAIL drain_lost: got %0d pending expected 0", sb.size());
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL drain_busy: got %b expected 0", busy);
    else passed++;
  endtask

  task automatic test_reset();
    int g;
    logic [NREQ-1:0] rdy;
    rst = 1'b1; hold = 1'b0; vld = '1;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 34'(i + 7);
      b_arr[i] = 32'(i + 9);
    end
    tick(g, rdy);
    tick(g, rdy);
    total++; if (rdy !== '0) $display("FAIL rst_ready: got %b expected 0", rdy); else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b expected 0", res_valid);
    else passed++;
    total++; if (res_id !== '0) $display("FAIL rst_res_id: got %0d expected 0", res_id); else passed++;
    total++; if (res_data !== '0) $display("FAIL rst_res_data: got %h expected 0", res_data);
    else passed++;
    total++; if (mul_a !== '0) $display("FAIL rst_mul_a: got %h expected 0", mul_a); else passed++;
    total++; if (mul_b !== '0) $display("FAIL rst_mul_b: got %h expected 0", mul_b); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
    rst = 1'b0; vld = '0;
  endtask

  task automatic test_single();
    int g;
    logic [NREQ-1:0] rdy;
    do_reset();
    vld = 4'b0100; a_arr[2] = 34'h3FFFFFFFF; b_arr[2] = 32'hFFFFFFFF;
    total++; if (busy !== 1'b0) $display("FAIL single_busy_pre: got %b expected 0", busy);
    else passed++;
    tick(g, rdy);
    vld = '0;
    for (int k = 0; k <= MUL_LAT; k++) begin
      total++; if (busy !== 1'b1) $display("FAIL single_busy_%0d: got %b expected 1", k, busy);
      else passed++;
      total++;
      if (res_valid !== 1'b0) $display("FAIL single_early_%0d: got %b expected 0", k, res_valid);
      else passed++;
      tick(g, rdy);
    end
    total++; if (res_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", res_valid);
    else passed++;
    total++; if (res_id !== 2'd2) $display("FAIL single_id: got %0d expected 2", res_id);
    else passed++;
    total++;
    if (res_data !== 66'h3FFFFFFFB00000001)
      $display("FAIL single_data: got %h expected 3fffffffb00000001", res_data);
    else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_busy_post: got %b expected 0", busy);
    else passed++;
    tick(g, rdy);
    total++; if (res_valid !== 1'b0) $display("FAIL single_once: got %b expected 0", res_valid);
    else passed++;
  endtask

  task automatic test_all_rr();
    int g;
    logic [NREQ-1:0] rdy, exp;
    logic [31:0] seen = '0;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 34'(i + 1);
      b_arr[i] = 32'h10;
    end
    for (int n = 0; n < 21; n++) begin
      seen[n] = res_valid;
      vld = (n < 8) ? '1 : '0;
      tick(g, rdy);
      if (n < 8) begin
        exp = '0; exp[n % 4] = 1'b1;
        total++; if (rdy !== exp) $display("FAIL rr_order_%0d: got %b expected %b", n, rdy, exp);
        else passed++;
      end
    end
    total++;
    if (seen !== 32'h00001FE0) $display("FAIL rr_b2b: got %h expected 00001fe0", seen);
    else passed++;
    drain();
  endtask

  task automatic test_two_req();
    int g;
    logic [NREQ-1:0] rdy, exp;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 34'(i * 4096 + 5);
      b_arr[i] = 32'(i * 3 + 1);
    end
    vld = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      tick(g, rdy);
      exp = (n % 2 == 0) ? 4'b0010 : 4'b1000;
      total++; if (rdy !== exp) $display("FAIL two_order_%0d: got %b expected %b", n, rdy, exp);
      else passed++;
    end
    vld = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      tick(g, rdy);
      total++; if (rdy !== 4'b0010) $display("FAIL two_single_%0d: got %b expected 0010", n, rdy);
      else passed++;
    end
    drain();
  endtask

  task automatic test_hold();
    int g, c0;
    logic [NREQ-1:0] rdy;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = rand_a();
      b_arr[i] = $urandom;
    end
    vld = '1;
    c0  = res_cnt;
    for (int n = 0; n < 3; n++) tick(g, rdy);
    hold = 1'b1;
    for (int h = 0; h < 6; h++) begin
      total++;
      if (busy !== (h <= MUL_LAT)) $display("FAIL hold_busy_%0d: got %b expected %b", h, busy,
                                           (h <= MUL_LAT));
      else passed++;
      tick(g, rdy);
      total++; if (rdy !== '0) $display("FAIL hold_ready_%0d: got %b expected 0", h, rdy);
      else passed++;
    end
    total++;
    if (res_cnt - c0 != 3) $display("FAIL hold_drain: got %0d expected 3", res_cnt - c0);
    else passed++;
    hold = 1'b0;
    tick(g, rdy);
    total++; if (rdy !== 4'b1000) $display("FAIL hold_resume: got %b expected 1000", rdy);
    else passed++;
    drain();
  endtask

  task automatic test_rst_inflight();
    int g, c0;
    logic [NREQ-1:0] rdy;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = rand_a();
      b_arr[i] = $urandom;
    end
    vld = '1;
    for (int n = 0; n < 3; n++) tick(g, rdy);
    rst = 1'b1;
    tick(g, rdy);
    rst = 1'b0; vld = '0;
    total++; if (res_valid !== 1'b0) $display("FAIL rfl_res_valid: got %b expected 0", res_valid);
    else passed++;
    total++; if (res_id !== '0) $display("FAIL rfl_res_id: got %0d expected 0", res_id); else passed++;
    total++; if (res_data !== '0) $display("FAIL rfl_res_data: got %h expected 0", res_data);
    else passed++;
    total++; if (mul_a !== '0) $display("FAIL rfl_mul_a: got %h expected 0", mul_a); else passed++;
    total++; if (mul_b !== '0) $display("FAIL rfl_mul_b: got %h expected 0", mul_b); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rfl_busy: got %b expected 0", busy); else passed++;
    c0 = res_cnt;
    for (int n = 0; n < MUL_LAT + 3; n++) tick(g, rdy);
    total++; if (res_cnt != c0) $display("FAIL rfl_ghost: got %0d expected 0", res_cnt - c0);
    else passed++;
    vld = '1;
    tick(g, rdy);
    total++; if (rdy !== 4'b0001) $display("FAIL rfl_first: got %b expected 0001", rdy);
    else passed++;
    drain();
  endtask

  task automatic test_random();
    int g, c0, issued;
    logic [NREQ-1:0] rdy;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      vld[i]   = 1'($urandom_range(0, 1));
      a_arr[i] = rand_a();
      b_arr[i] = $urandom;
    end
    c0 = res_cnt; issued = 0;
    for (int n = 0; n < 10000; n++) begin
      hold = ($urandom_range(0, 4) == 0);
      tick(g, rdy);
      if (g >= 0) issued++;
      for (int i = 0; i < NREQ; i++) begin
        if (i == g || !vld[i]) begin
          vld[i]   = ($urandom_range(0, 2) != 0);
          a_arr[i] = rand_a();
          b_arr[i] = $urandom;
        end
      end
    end
    drain();
    total++;
    if (res_cnt - c0 != issued) $display("FAIL rand_count: got %0d expected %0d", res_cnt - c0,
                                         issued);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; vld = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    drive();
    @(negedge clk);
    test_reset();
    test_single();
    test_all_rr();
    test_two_req();
    test_hold();
    test_rst_inflight();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
